// File: rtl/regfile_mp.sv
// Multi-port integer register file: hardwired-zero r0, optional write-to-read
// bypass, post-reset clear sweep and a per-register busy scoreboard.

module regfile_mp_rd #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = 5
) (
    input  logic                       run,
    input  logic [AW-1:0]              addr,
    input  logic [NREG-1:0][XLEN-1:0]  mem,
    input  logic [NREG-1:0]            busy,
    input  logic [NWR-1:0]             wr_en,
    input  logic [NWR*AW-1:0]          wr_addr,
    input  logic [NWR*XLEN-1:0]        wr_data,
    output logic [XLEN-1:0]            data,
    output logic                       busy_o
);
    always_comb begin
        data   = '0;
        busy_o = 1'b0;
        if (run && addr != '0) begin
            data   = mem[addr];
            busy_o = busy[addr];
            // Ascending scan so the highest-index matching port wins.
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && wr_addr[w*AW +: AW] == addr)
                        data = wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [NRD*AW-1:0]    rs_addr,
    output logic [NRD*XLEN-1:0]  rs_data,
    output logic [NRD-1:0]       rs_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd
);
    typedef enum logic {INIT, RUN} state_t;

    state_t                     state, state_nxt;
    logic [AW-1:0]              cnt, cnt_nxt;
    logic                       sweep_we;
    logic                       run;
    logic                       run_we;
    logic [NREG-1:0][XLEN-1:0]  mem;
    logic [NREG-1:0]            busy;

    assign run    = (state == RUN);
    assign run_we = run && !rst;
    assign ready  = run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= AW'(1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sweep_we  = 1'b0;
        case (state)
            INIT: begin
                sweep_we = 1'b1;
                cnt_nxt  = cnt + AW'(1);
                if (cnt == AW'(NREG-1))
                    state_nxt = RUN;
            end
            RUN: ;
            default: state_nxt = INIT;
        endcase
    end

    // Later ports override earlier ones on address collisions.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[cnt] <= '0;
        end else if (run_we) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
                    mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
        end
        mem[0] <= '0;
    end

    // Issue set is applied after write clears so a new producer stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (run) begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w])
                    busy[wr_addr[w*AW +: AW]] <= 1'b0;
            end
            if (iss_en && iss_rd != '0)
                busy[iss_rd] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_mp_rd #(
            .XLEN(XLEN), .NREG(NREG), .NWR(NWR), .BYPASS(BYPASS), .AW(AW)
        ) u_rd (
            .run    (run),
            .addr   (rs_addr[k*AW +: AW]),
            .mem    (mem),
            .busy   (busy),
            .wr_en  (wr_en),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .data   (rs_data[k*XLEN +: XLEN]),
            .busy_o (rs_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass and no-bypass instances share stimulus and are
// checked against an array-based reference model.

module tb_regfile_mp;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NRD*AW-1:0]    rs_addr = '0;
    logic [NWR-1:0]       wr_en = '0;
    logic [NWR*AW-1:0]    wr_addr = '0;
    logic [NWR*XLEN-1:0]  wr_data = '0;
    logic                 iss_en = 1'b0;
    logic [AW-1:0]        iss_rd = '0;

    logic                 ready_b, ready_n;
    logic [NRD*XLEN-1:0]  rs_data_b, rs_data_n;
    logic [NRD-1:0]       rs_busy_b, rs_busy_n;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [XLEN-1:0] m_mem [NREG];
    bit   [NREG-1:0] m_busy;
    int              m_sweep = NREG - 1;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .ready(ready_b),
        .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .ready(ready_n),
        .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd)
    );

    task automatic model_edge();
        logic [AW-1:0] a;
        if (rst) begin
            m_sweep = NREG - 1;
            m_busy  = '0;
            for (int r = 0; r < NREG; r++) m_mem[r] = '0;
        end else if (m_sweep > 0) begin
            m_sweep--;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                a = wr_addr[w*AW +: AW];
                if (wr_en[w] && a != 0) begin
                    m_mem[a]  = wr_data[w*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    function automatic logic [XLEN-1:0] exp_data(input bit byp, input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (m_sweep > 0 || a == 0) return '0;
        v = m_mem[a];
        if (byp)
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[w*AW +: AW] == a) v = wr_data[w*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (m_sweep > 0 || a == 0) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_sweep();
        for (int i = 0; i < NREG - 1; i++) tick();
    endtask

    task automatic test_reset();
        idle();
        do_reset();
        total++;
        if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b/%b want 0", ready_b, ready_n);
        end
        rs_addr[0 +: AW] = 5'd5;
        #1;
        total++;
        if (rs_data_b[0 +: XLEN] !== '0 || rs_busy_b !== '0) begin
            bad++; $display("FAIL reset_rd: got %h busy %b want 0", rs_data_b[0 +: XLEN], rs_busy_b);
        end
        run_sweep();
        total++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            bad++; $display("FAIL reset_ready_up: got %b/%b want 1", ready_b, ready_n);
        end
    endtask

    task automatic test_sweep_clears();
        int errs = 0;
        set_wr(0, 5'd5, 64'hDEAD);
        tick();
        idle();
        rs_addr[0 +: AW] = 5'd5;
        #1;
        total++;
        if (rs_data_b[0 +: XLEN] !== 64'hDEAD) begin
            bad++; $display("FAIL preload_r5: got %h want dead", rs_data_b[0 +: XLEN]);
        end
        do_reset();
        for (int i = 1; i <= NREG - 1; i++) begin
            total++;
            if (ready_b !== 1'b0 || rs_data_b[0 +: XLEN] !== '0 || rs_data_n[0 +: XLEN] !== '0) begin
                bad++; $display("FAIL sweep_cycle%0d: ready %b data %h want 0/0", i, ready_b, rs_data_b[0 +: XLEN]);
            end
            tick();
        end
        total++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            bad++; $display("FAIL sweep_ready: got %b/%b want 1", ready_b, ready_n);
        end
        total++;
        if (rs_data_b[0 +: XLEN] !== '0 || rs_data_n[0 +: XLEN] !== '0) begin
            bad++; $display("FAIL sweep_r5: got %h/%h want 0", rs_data_b[0 +: XLEN], rs_data_n[0 +: XLEN]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        for (int i = 1; i <= NREG - 1; i++) begin
            total++;
            if (ready_b !== 1'b0) begin
                bad++; $display("FAIL mid_reset_early cyc%0d: got %b want 0", i, ready_b);
            end
            tick();
        end
        total++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            bad++; $display("FAIL mid_reset_ready: got %b/%b want 1", ready_b, ready_n);
        end
    endtask

    task automatic test_bypass();
        set_wr(0, 5'd3, 64'h1111);
        tick();
        idle();
        set_wr(0, 5'd3, 64'h1234);
        rs_addr[0 +: AW] = 5'd3;
        #1;
        total++;
        if (rs_data_b[0 +: XLEN] !== 64'h1234) begin
            bad++; $display("FAIL bypass_same: got %h want 1234", rs_data_b[0 +: XLEN]);
        end
        total++;
        if (rs_data_n[0 +: XLEN] !== 64'h1111) begin
            bad++; $display("FAIL nobypass_same: got %h want 1111", rs_data_n[0 +: XLEN]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rs_data_n[0 +: XLEN] !== 64'h1234 || rs_data_b[0 +: XLEN] !== 64'h1234) begin
            bad++; $display("FAIL bypass_next: got %h/%h want 1234", rs_data_b[0 +: XLEN], rs_data_n[0 +: XLEN]);
        end
    endtask

    task automatic test_zero_collision();
        set_wr(0, 5'd0, 64'hFF);
        rs_addr[0 +: AW] = 5'd0;
        #1;
        total++;
        if (rs_data_b[0 +: XLEN] !== '0) begin
            bad++; $display("FAIL r0_bypass: got %h want 0", rs_data_b[0 +: XLEN]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rs_data_b[0 +: XLEN] !== '0 || rs_data_n[0 +: XLEN] !== '0) begin
            bad++; $display("FAIL r0_read: got %h/%h want 0", rs_data_b[0 +: XLEN], rs_data_n[0 +: XLEN]);
        end
        set_wr(0, 5'd7, 64'hAA);
        set_wr(1, 5'd7, 64'hBB);
        rs_addr[AW +: AW] = 5'd7;
        #1;
        total++;
        if (rs_data_b[XLEN +: XLEN] !== 64'hBB) begin
            bad++; $display("FAIL collide_bypass: got %h want bb", rs_data_b[XLEN +: XLEN]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rs_data_b[XLEN +: XLEN] !== 64'hBB || rs_data_n[XLEN +: XLEN] !== 64'hBB) begin
            bad++; $display("FAIL collide_store: got %h/%h want bb", rs_data_b[XLEN +: XLEN], rs_data_n[XLEN +: XLEN]);
        end
    endtask

    task automatic test_scoreboard();
        rs_addr[0 +: AW] = 5'd9;
        rs_addr[AW +: AW] = 5'd0;
        iss_en = 1'b1; iss_rd = 5'd9;
        #1;
        total++;
        if (rs_busy_b[0] !== 1'b0) begin
            bad++; $display("FAIL sb_issue_same: got %b want 0", rs_busy_b[0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rs_busy_b[0] !== 1'b1 || rs_busy_n[0] !== 1'b1) begin
            bad++; $display("FAIL sb_set: got %b/%b want 1", rs_busy_b[0], rs_busy_n[0]);
        end
        set_wr(0, 5'd9, 64'h99);
        #1;
        total++;
        if (rs_busy_b[0] !== 1'b1) begin
            bad++; $display("FAIL sb_write_cycle: got %b want 1", rs_busy_b[0]);
        end
        tick();
        idle();
        #1;
        total++;
        if (rs_busy_b[0] !== 1'b0) begin
            bad++; $display("FAIL sb_clear: got %b want 0", rs_busy_b[0]);
        end
        iss_en = 1'b1; iss_rd = 5'd9;
        tick();
        set_wr(1, 5'd9, 64'h98);
        tick();
        idle();
        #1;
        total++;
        if (rs_busy_b[0] !== 1'b1) begin
            bad++; $display("FAIL sb_set_wins: got %b want 1", rs_busy_b[0]);
        end
        set_wr(0, 5'd9, 64'h97);
        tick();
        idle();
        iss_en = 1'b1; iss_rd = 5'd0;
        tick();
        idle();
        #1;
        total++;
        if (rs_busy_b !== 2'b00) begin
            bad++; $display("FAIL sb_r0: got %b want 00", rs_busy_b);
        end
    endtask

    task automatic test_init_ignores();
        do_reset();
        rs_addr[0 +: AW] = 5'd4;
        for (int i = 0; i < 20; i++) begin
            set_wr(0, 5'd4, 64'h55);
            iss_en = 1'b1; iss_rd = 5'd4;
            #1;
            total++;
            if (rs_data_b[0 +: XLEN] !== '0 || rs_busy_b[0] !== 1'b0) begin
                bad++; $display("FAIL init_rd cyc%0d: got %h busy %b want 0", i, rs_data_b[0 +: XLEN], rs_busy_b[0]);
            end
            tick();
        end
        idle();
        for (int i = 20; i < NREG - 1; i++) tick();
        total++;
        if (ready_b !== 1'b1 || rs_data_b[0 +: XLEN] !== '0 || rs_busy_b[0] !== 1'b0) begin
            bad++; $display("FAIL init_ignored: ready %b data %h busy %b want 1/0/0", ready_b, rs_data_b[0 +: XLEN], rs_busy_b[0]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NWR; p++) begin
                wr_en[p] = $urandom_range(0, 1);
                wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[p*XLEN +: XLEN] = {$urandom, $urandom};
            end
            iss_en = $urandom_range(0, 1);
            iss_rd = AW'($urandom_range(0, 7));
            for (int k = 0; k < NRD; k++) rs_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
            #1;
            total++;
            if (ready_b !== (m_sweep == 0) || ready_n !== (m_sweep == 0)) begin
                bad++; $display("FAIL rand_ready cyc%0d: got %b/%b want %b", c, ready_b, ready_n, m_sweep == 0);
            end
            for (int k = 0; k < NRD; k++) begin
                a = rs_addr[k*AW +: AW];
                total++;
                if (rs_data_b[k*XLEN +: XLEN] !== exp_data(1'b1, a)) begin
                    bad++; $display("FAIL rand_byp cyc%0d port%0d r%0d: got %h want %h", c, k, a, rs_data_b[k*XLEN +: XLEN], exp_data(1'b1, a));
                end
                total++;
                if (rs_data_n[k*XLEN +: XLEN] !== exp_data(1'b0, a)) begin
                    bad++; $display("FAIL rand_nob cyc%0d port%0d r%0d: got %h want %h", c, k, a, rs_data_n[k*XLEN +: XLEN], exp_data(1'b0, a));
                end
                total++;
                if (rs_busy_b[k] !== exp_busy(a) || rs_busy_n[k] !== exp_busy(a)) begin
                    bad++; $display("FAIL rand_busy cyc%0d port%0d r%0d: got %b/%b want %b", c, k, a, rs_busy_b[k], rs_busy_n[k], exp_busy(a));
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        #2;
        test_reset();
        test_sweep_clears();
        test_mid_reset();
        test_bypass();
        test_zero_collision();
        test_scoreboard();
        test_init_ignores();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
